// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for the CPU timing logic.
// Holds the sequencer state encoding and the default T-state width so that
// the sequencer and the downstream timing decoder are always built with the
// same step width.
package cpu_ctrl_pkg;

    // Default T-state index width; the last step is 2**DEFAULT_STEP_WIDTH-1.
    localparam int DEFAULT_STEP_WIDTH = 3;

    // Sequencer state encoding.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] EXEC   = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_FETCH  = FETCH,
        ST_EXEC   = EXEC,
        ST_HALTED = HALTED
    } state_t;

endpackage

// File: rtl/step_counter.sv
// T-state step counter used by the instruction step sequencer.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clr        : force the count back to zero (wins over everything else)
//   inc        : advance by one step
//   hold       : freeze the count (wins over inc)
//   value      : current step index
//   at_max     : high when value is the last step (all ones)
module step_counter
    import cpu_ctrl_pkg::*;
#(
    parameter int STEP_WIDTH = DEFAULT_STEP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  inc,
    input  logic                  hold,
    output logic [STEP_WIDTH-1:0] value,
    output logic                  at_max
);

    logic [STEP_WIDTH-1:0] r_value;

    // Step register. Clear beats hold, and hold beats increment, so a stalled
    // step never moves even if the control logic also requests an advance.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_value <= '0;
        end else if (!hold && inc) begin
            r_value <= r_value + STEP_WIDTH'(1);
        end
    end

    assign value  = r_value;
    assign at_max = (r_value == '1);

endmodule

// File: rtl/instr_step_sequencer.sv
// Control-path timing generator. Fetches an opcode into the instruction
// register, then walks the T-state counter through the execution steps,
// handling memory waits, execution stalls, early instruction end and halt
// requests taken at instruction boundaries.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   start        : leave IDLE/HALTED and begin fetching
//   halt_req     : pulse; halt at the next instruction boundary
//   mem_ready    : opcode on ir_in is valid this cycle
//   ir_in        : opcode from the memory data bus
//   stall        : hold the current execution step
//   ins_end      : current step is the last one for this opcode
//   fetch_req    : opcode read request
//   ir_out       : instruction register
//   step_sel     : T-state index for the timing decoder
//   step_en      : T-state valid for the timing decoder
//   running      : in FETCH or EXEC
//   halted       : in HALTED
//   instr_count  : retired instruction count, wraps silently
module instr_step_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int STEP_WIDTH   = DEFAULT_STEP_WIDTH,
    parameter int OPCODE_WIDTH = 8,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    halt_req,
    input  logic                    mem_ready,
    input  logic [OPCODE_WIDTH-1:0] ir_in,
    input  logic                    stall,
    input  logic                    ins_end,
    output logic                    fetch_req,
    output logic [OPCODE_WIDTH-1:0] ir_out,
    output logic [STEP_WIDTH-1:0]   step_sel,
    output logic                    step_en,
    output logic                    running,
    output logic                    halted,
    output logic [COUNT_WIDTH-1:0]  instr_count
);

    state_t                  r_state;
    logic [OPCODE_WIDTH-1:0] r_ir;
    logic [COUNT_WIDTH-1:0]  r_instrCount;
    logic                    r_haltPending;

    logic                    w_stepClr;
    logic                    w_stepInc;
    logic                    w_stepHold;
    logic                    w_instrDone;
    logic [STEP_WIDTH-1:0]   w_stepValue;
    logic                    w_stepAtMax;

    step_counter #(
        .STEP_WIDTH(STEP_WIDTH)
    ) u_stepCounter (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_stepClr),
        .inc    (w_stepInc),
        .hold   (w_stepHold),
        .value  (w_stepValue),
        .at_max (w_stepAtMax)
    );

    // Step counter control. The step sits at 0 outside EXEC, so the opcode
    // capture in FETCH is just an increment from T0 to T1. In EXEC a stall
    // freezes everything, including a same-cycle ins_end; otherwise the
    // instruction ends on ins_end or when the last step is reached.
    always_comb begin
        w_stepClr   = 1'b0;
        w_stepInc   = 1'b0;
        w_stepHold  = 1'b0;
        w_instrDone = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALTED: w_stepClr = 1'b1;
            ST_FETCH:           w_stepInc = mem_ready;
            ST_EXEC: begin
                if (stall) begin
                    w_stepHold = 1'b1;
                end else if (ins_end || w_stepAtMax) begin
                    w_instrDone = 1'b1;
                    w_stepClr   = 1'b1;
                end else begin
                    w_stepInc = 1'b1;
                end
            end
            default: w_stepClr = 1'b1;
        endcase
    end

    // Main sequencer FSM with the instruction register, halt latch and retired
    // counter. A halt request seen on the very cycle an instruction ends is
    // honoured immediately rather than being latched for the next boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ir          <= '0;
            r_instrCount  <= '0;
            r_haltPending <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (halt_req) r_haltPending <= 1'b1;
                    if (mem_ready) begin
                        r_ir    <= ir_in;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_instrDone) begin
                        r_instrCount <= r_instrCount + COUNT_WIDTH'(1);
                        if (r_haltPending || halt_req) begin
                            r_state       <= ST_HALTED;
                            r_haltPending <= 1'b0;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end else if (halt_req) begin
                        r_haltPending <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (start) r_state <= ST_FETCH;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded purely from registered state.
    assign fetch_req   = (r_state == ST_FETCH);
    assign step_en     = (r_state == ST_FETCH) || (r_state == ST_EXEC);
    assign running     = step_en;
    assign halted      = (r_state == ST_HALTED);
    assign step_sel    = (r_state == ST_EXEC) ? w_stepValue : '0;
    assign ir_out      = r_ir;
    assign instr_count = r_instrCount;

endmodule

// File: tb/tb_instr_step_sequencer.sv
// Self-checking bench for instr_step_sequencer: a table of directed vectors,
// hand-written multi-cycle sequences, then randomized stimulus compared
// against a behavioural model of the sequencing rules.
module tb_instr_step_sequencer;

    localparam int SW       = 3;
    localparam int OW       = 8;
    localparam int CW       = 16;
    localparam int LAST     = (1 << SW) - 1;
    localparam int M_IDLE   = 0;
    localparam int M_FETCH  = 1;
    localparam int M_EXEC   = 2;
    localparam int M_HALTED = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          halt_req = 1'b0;
    logic          mem_ready = 1'b0;
    logic [OW-1:0] ir_in = '0;
    logic          stall = 1'b0;
    logic          ins_end = 1'b0;
    logic          fetch_req;
    logic [OW-1:0] ir_out;
    logic [SW-1:0] step_sel;
    logic          step_en;
    logic          running;
    logic          halted;
    logic [CW-1:0] instr_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model: which phase we are in, the current T-state, the
    // captured opcode, retired count and whether a halt is owed.
    int            mMode = M_IDLE;
    int            mStep = 0;
    int            mCnt  = 0;
    bit            mPend = 0;
    logic [OW-1:0] mIr   = '0;

    typedef struct {
        string         name;
        logic          rst, st, hr, mr;
        logic [OW-1:0] ir;
        logic          stl, ie;
        logic          eF;
        logic [OW-1:0] eIr;
        int            eSel;
        logic          eEn, eRun, eHalt;
        int            eCnt;
    } vec_t;

    vec_t vecs[$];

    instr_step_sequencer #(
        .STEP_WIDTH(SW),
        .OPCODE_WIDTH(OW),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt_req    (halt_req),
        .mem_ready   (mem_ready),
        .ir_in       (ir_in),
        .stall       (stall),
        .ins_end     (ins_end),
        .fetch_req   (fetch_req),
        .ir_out      (ir_out),
        .step_sel    (step_sel),
        .step_en     (step_en),
        .running     (running),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock using the rules of the sequencer.
    task automatic modelStep(input logic r, s, h, m, input logic [OW-1:0] d,
                             input logic stl, ie);
        if (r) begin
            mMode = M_IDLE; mStep = 0; mIr = '0; mCnt = 0; mPend = 0;
        end else if (mMode == M_IDLE || mMode == M_HALTED) begin
            if (s) mMode = M_FETCH;
        end else if (mMode == M_FETCH) begin
            if (h) mPend = 1;
            if (m) begin
                mIr = d; mStep = 1; mMode = M_EXEC;
            end
        end else begin
            if (stl) begin
                if (h) mPend = 1;
            end else if (ie || mStep == LAST) begin
                mCnt  = (mCnt + 1) % (1 << CW);
                mStep = 0;
                if (mPend || h) begin
                    mMode = M_HALTED; mPend = 0;
                end else begin
                    mMode = M_FETCH;
                end
            end else begin
                if (h) mPend = 1;
                mStep = mStep + 1;
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, and advance the model.
    task automatic applyStimulus(input logic r, s, h, m, input logic [OW-1:0] d,
                                 input logic stl, ie);
        reset = r; start = s; halt_req = h; mem_ready = m;
        ir_in = d; stall = stl; ins_end = ie;
        @(posedge clk);
        #1;
        modelStep(r, s, h, m, d, stl, ie);
    endtask

    task automatic checkOutput(input string name, input logic eF,
                               input logic [OW-1:0] eIr, input int eSel,
                               input logic eEn, eRun, eHalt, input int eCnt);
        checks++;
        if (fetch_req !== eF || ir_out !== eIr || step_sel !== SW'(eSel) ||
            step_en !== eEn || running !== eRun || halted !== eHalt ||
            instr_count !== CW'(eCnt)) begin
            errors++;
            $display("[TB] FAIL %s: got fetch=%0b ir=%h sel=%0d en=%0b run=%0b halt=%0b cnt=%0d, want fetch=%0b ir=%h sel=%0d en=%0b run=%0b halt=%0b cnt=%0d",
                     name, fetch_req, ir_out, step_sel, step_en, running, halted, instr_count,
                     eF, eIr, eSel, eEn, eRun, eHalt, eCnt);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, mMode == M_FETCH, mIr, (mMode == M_EXEC) ? mStep : 0,
                    mMode == M_FETCH || mMode == M_EXEC,
                    mMode == M_FETCH || mMode == M_EXEC,
                    mMode == M_HALTED, mCnt);
    endtask

    task automatic addVec(input string n, input logic r, s, h, m, input logic [OW-1:0] d,
                          input logic stl, ie, input logic eF, input logic [OW-1:0] eIr,
                          input int eSel, input logic eEn, eRun, eHalt, input int eCnt);
        vec_t v;
        v.name = n; v.rst = r; v.st = s; v.hr = h; v.mr = m; v.ir = d;
        v.stl = stl; v.ie = ie; v.eF = eF; v.eIr = eIr; v.eSel = eSel;
        v.eEn = eEn; v.eRun = eRun; v.eHalt = eHalt; v.eCnt = eCnt;
        vecs.push_back(v);
    endtask

    // Shorthand for a directed cycle checked against fixed expectations.
    task automatic step(input string n, input logic r, s, h, m, input logic [OW-1:0] d,
                        input logic stl, ie, input logic eF, input logic [OW-1:0] eIr,
                        input int eSel, input logic eEn, eRun, eHalt, input int eCnt);
        applyStimulus(r, s, h, m, d, stl, ie);
        checkOutput(n, eF, eIr, eSel, eEn, eRun, eHalt, eCnt);
    endtask

    initial begin
        // Full-length instruction, wrap back to FETCH, then an early end at T3.
        addVec("reset",        1,0,0,0,8'h00,0,0, 0,8'h00,0,0,0,0,0);
        addVec("idle_halt",    0,0,1,0,8'h00,0,0, 0,8'h00,0,0,0,0,0);
        addVec("start",        0,1,0,0,8'h00,0,0, 1,8'h00,0,1,1,0,0);
        addVec("fetch_a5",     0,0,0,1,8'hA5,0,0, 0,8'hA5,1,1,1,0,0);
        for (int k = 2; k <= LAST; k++)
            addVec($sformatf("step%0d", k), 0,0,0,0,8'h00,0,0, 0,8'hA5,k,1,1,0,0);
        addVec("last_wrap",    0,0,0,0,8'h00,0,0, 1,8'hA5,0,1,1,0,1);
        addVec("fetch_3c",     0,0,0,1,8'h3C,0,0, 0,8'h3C,1,1,1,0,1);
        addVec("s2",           0,0,0,0,8'h00,0,0, 0,8'h3C,2,1,1,0,1);
        addVec("s3",           0,0,0,0,8'h00,0,0, 0,8'h3C,3,1,1,0,1);
        addVec("ins_end_s3",   0,0,0,0,8'h00,0,1, 1,8'h3C,0,1,1,0,2);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].hr, vecs[i].mr,
                          vecs[i].ir, vecs[i].stl, vecs[i].ie);
            checkOutput(vecs[i].name, vecs[i].eF, vecs[i].eIr, vecs[i].eSel,
                        vecs[i].eEn, vecs[i].eRun, vecs[i].eHalt, vecs[i].eCnt);
        end

        // Memory wait: opcode register must not move until mem_ready.
        for (int k = 0; k < 4; k++)
            step("mem_wait", 0,0,0,0,8'hFF,0,0, 1,8'h3C,0,1,1,0,2);
        step("fetch_5a",       0,0,0,1,8'h5A,0,0, 0,8'h5A,1,1,1,0,2);

        // Stall at T2 beats a same-cycle ins_end.
        step("to_s2",          0,0,0,0,8'h00,0,0, 0,8'h5A,2,1,1,0,2);
        step("stall_ie",       0,0,0,0,8'h00,1,1, 0,8'h5A,2,1,1,0,2);
        step("stall2",         0,0,0,0,8'h00,1,0, 0,8'h5A,2,1,1,0,2);
        step("stall3",         0,0,0,0,8'h00,1,0, 0,8'h5A,2,1,1,0,2);
        step("after_stall",    0,0,0,0,8'h00,0,0, 0,8'h5A,3,1,1,0,2);
        step("end_5a",         0,0,0,0,8'h00,0,1, 1,8'h5A,0,1,1,0,3);

        // Halt requested at T1, honoured at the T4 boundary.
        step("fetch_c3",       0,0,0,1,8'hC3,0,0, 0,8'hC3,1,1,1,0,3);
        step("halt_pulse",     0,0,1,0,8'h00,0,0, 0,8'hC3,2,1,1,0,3);
        step("pend_s3",        0,0,0,0,8'h00,0,0, 0,8'hC3,3,1,1,0,3);
        step("pend_s4",        0,0,0,0,8'h00,0,0, 0,8'hC3,4,1,1,0,3);
        step("halt_enter",     0,0,0,0,8'h00,0,1, 0,8'hC3,0,0,0,1,4);
        step("halted_hr",      0,0,1,1,8'h77,0,0, 0,8'hC3,0,0,0,1,4);
        step("halted_hold",    0,0,0,0,8'h00,0,0, 0,8'hC3,0,0,0,1,4);
        step("resume",         0,1,0,0,8'h00,0,0, 1,8'hC3,0,1,1,0,4);

        // Halt request on the same cycle as the instruction end.
        step("fetch_11",       0,0,0,1,8'h11,0,0, 0,8'h11,1,1,1,0,4);
        step("halt_same",      0,0,1,0,8'h00,0,1, 0,8'h11,0,0,0,1,5);
        step("resume2",        0,1,0,0,8'h00,0,0, 1,8'h11,0,1,1,0,5);

        // Reset in the middle of execution and in the middle of a fetch.
        step("fetch_22",       0,0,0,1,8'h22,0,0, 0,8'h22,1,1,1,0,5);
        for (int k = 2; k <= 5; k++)
            step("run_to_s5",  0,0,0,0,8'h00,0,0, 0,8'h22,k,1,1,0,5);
        step("reset_exec",     1,1,1,1,8'h99,0,1, 0,8'h00,0,0,0,0,0);
        step("start2",         0,1,0,0,8'h00,0,0, 1,8'h00,0,1,1,0,0);
        step("fetch_hr",       0,0,1,0,8'h00,0,0, 1,8'h00,0,1,1,0,0);
        step("reset_fetch",    1,0,0,1,8'h99,0,0, 0,8'h00,0,0,0,0,0);
        step("start3",         0,1,0,0,8'h00,0,0, 1,8'h00,0,1,1,0,0);
        step("fetch_44",       0,0,0,1,8'h44,0,0, 0,8'h44,1,1,1,0,0);
        step("pend_cleared",   0,0,0,0,8'h00,0,1, 1,8'h44,0,1,1,0,1);

        // Randomized run against the behavioural model.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 99) < 30,
                          $urandom_range(0, 99) < 6,
                          $urandom_range(0, 99) < 50,
                          OW'($urandom),
                          $urandom_range(0, 99) < 20,
                          $urandom_range(0, 99) < 12);
            checkModel("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
